// File: rtl/mood_window_ctrl.sv
// Measurement sequencer: frames prescaler-tick windows, latches the edge count
// at each window end and classifies it into a hysteretic 2-bit mood.
module mood_window_ctrl #(
    parameter int CNT_W     = 4,
    parameter int WIN_TICKS = 8,
    parameter int LO_TH     = 2,
    parameter int HI_TH     = 6,
    parameter int HYST      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             stop,
    input  logic             tick,
    input  logic [CNT_W-1:0] cnt_val,
    output logic             presc_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             win_done,
    output logic [CNT_W-1:0] win_count,
    output logic [1:0]       mood
);

    localparam int                TICK_W    = (WIN_TICKS > 1) ? $clog2(WIN_TICKS) : 1;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(WIN_TICKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_MEASURE = 3'd2;
    localparam logic [2:0] S_LATCH   = 3'd3;
    localparam logic [2:0] S_EVAL    = 3'd4;

    localparam logic [1:0] MOOD_CALM     = 2'd0;
    localparam logic [1:0] MOOD_CONTENT  = 2'd1;
    localparam logic [1:0] MOOD_STRESSED = 2'd2;

    logic [2:0]        r_state;
    logic [TICK_W-1:0] r_tick_cnt;
    logic              r_stop_pend;
    logic [CNT_W-1:0]  r_win_count;
    logic [1:0]        r_mood;

    logic [2:0]        w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic              w_stop_nxt;
    logic              w_latch;
    logic [1:0]        w_mood_nxt;

    // Rising moods need HYST extra counts; falling moods use the bare thresholds.
    always_comb begin
        w_mood_nxt = r_mood;
        case (r_mood)
            MOOD_CALM: begin
                if (int'(cnt_val) >= HI_TH + HYST)      w_mood_nxt = MOOD_STRESSED;
                else if (int'(cnt_val) >= LO_TH + HYST) w_mood_nxt = MOOD_CONTENT;
                else                                    w_mood_nxt = MOOD_CALM;
            end
            MOOD_CONTENT: begin
                if (int'(cnt_val) >= HI_TH + HYST)      w_mood_nxt = MOOD_STRESSED;
                else if (int'(cnt_val) < LO_TH)         w_mood_nxt = MOOD_CALM;
                else                                    w_mood_nxt = MOOD_CONTENT;
            end
            default: begin
                if (int'(cnt_val) < LO_TH)              w_mood_nxt = MOOD_CALM;
                else if (int'(cnt_val) < HI_TH)         w_mood_nxt = MOOD_CONTENT;
                else                                    w_mood_nxt = MOOD_STRESSED;
            end
        endcase
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_stop_nxt  = r_stop_pend;
        w_latch     = 1'b0;
        if (r_state != S_IDLE && !ena) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && ena && !stop) w_state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    w_tick_nxt  = '0;
                    w_stop_nxt  = stop;
                    w_state_nxt = S_MEASURE;
                end
                S_MEASURE: begin
                    if (stop) w_stop_nxt = 1'b1;
                    if (tick) begin
                        if (r_tick_cnt == LAST_TICK) w_state_nxt = S_LATCH;
                        else                         w_tick_nxt  = r_tick_cnt + TICK_W'(1);
                    end
                end
                S_LATCH: begin
                    if (stop) w_stop_nxt = 1'b1;
                    w_latch     = 1'b1;
                    w_state_nxt = S_EVAL;
                end
                S_EVAL: begin
                    if (r_stop_pend || stop) begin
                        w_state_nxt = S_IDLE;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_CLEAR;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_stop_pend <= 1'b0;
            r_win_count <= '0;
            r_mood      <= MOOD_CALM;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_stop_pend <= w_stop_nxt;
            if (w_latch) begin
                r_win_count <= cnt_val;
                r_mood      <= w_mood_nxt;
            end
        end
    end

    assign presc_en  = (r_state == S_MEASURE);
    assign cnt_clr   = (r_state == S_CLEAR);
    assign busy      = (r_state != S_IDLE);
    assign win_done  = (r_state == S_EVAL);
    assign win_count = r_win_count;
    assign mood      = r_mood;

endmodule

// File: tb/tb_mood_window_ctrl.sv
// Bench for mood_window_ctrl: table of window counts with expected mood,
// scoreboard checked on win_done, plus hand sequences for stop/ena/reset.
module tb_mood_window_ctrl;

    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] cnt_val = 4'd0;
    logic       presc_en, cnt_clr, busy, win_done;
    logic [3:0] win_count;
    logic [1:0] mood;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    typedef struct packed {
        logic [3:0] c;
        logic [1:0] m;
    } exp_t;

    typedef struct {
        logic [3:0] cnt;
        logic [1:0] exp_mood;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[11];

    mood_window_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
        .tick(tick), .cnt_val(cnt_val), .presc_en(presc_en), .cnt_clr(cnt_clr),
        .busy(busy), .win_done(win_done), .win_count(win_count), .mood(mood)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every win_done pops the window result queued when its stimulus was driven.
    always @(negedge clk) begin
        if (rst_n && win_done) begin
            exp_t e;
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_win_done: got win_count %0d mood %0d expected no pulse (t=%0t)",
                         win_count, mood, $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_win_count", win_count, e.c);
                check("sb_mood", mood, e.m);
            end
        end
    end

    // Entered at the negedge where MEASURE is first visible; returns at the EVAL negedge.
    task automatic run_window(input int gap, input logic [3:0] c, input logic [1:0] em, input int stop_k);
        cnt_val = c;
        sb_q.push_back('{c: c, m: em});
        for (int k = 0; k < WIN; k++) begin
            tick = 1'b0;
            repeat (gap) @(negedge clk);
            check("presc_en_measure", presc_en, 1);
            tick = 1'b1;
            stop = (k == stop_k);
            @(negedge clk);
            tick = 1'b0;
            stop = 1'b0;
        end
        check("presc_en_latch", presc_en, 0);
        check("win_done_latch", win_done, 0);
        check("busy_latch", busy, 1);
        @(negedge clk);
        check("win_done_eval", win_done, 1);
    endtask

    initial begin
        tbl[0]  = '{cnt: 4'd2,  exp_mood: 2'd1};
        tbl[1]  = '{cnt: 4'd1,  exp_mood: 2'd0};
        tbl[2]  = '{cnt: 4'd2,  exp_mood: 2'd0};
        tbl[3]  = '{cnt: 4'd7,  exp_mood: 2'd2};
        tbl[4]  = '{cnt: 4'd6,  exp_mood: 2'd2};
        tbl[5]  = '{cnt: 4'd5,  exp_mood: 2'd1};
        tbl[6]  = '{cnt: 4'd6,  exp_mood: 2'd1};
        tbl[7]  = '{cnt: 4'd0,  exp_mood: 2'd0};
        tbl[8]  = '{cnt: 4'd15, exp_mood: 2'd2};
        tbl[9]  = '{cnt: 4'd1,  exp_mood: 2'd0};
        tbl[10] = '{cnt: 4'd3,  exp_mood: 2'd1};

        ena = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_presc_en", presc_en, 0);
        check("rst_cnt_clr", cnt_clr, 0);
        check("rst_busy", busy, 0);
        check("rst_win_done", win_done, 0);
        check("rst_win_count", win_count, 0);
        check("rst_mood", mood, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // First window: ticks every 4 cycles, count 3 lifts calm to content.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("w1_cnt_clr", cnt_clr, 1);
        check("w1_presc_en_clear", presc_en, 0);
        check("w1_busy", busy, 1);
        @(negedge clk);
        check("w1_cnt_clr_once", cnt_clr, 0);
        run_window(3, 4'd3, 2'd1, -1);

        // Back-to-back windows; a tick during CLEAR must be ignored. Stop at the 4th tick of the last.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("gap_cnt_clr", cnt_clr, 1);
            check("gap_win_done", win_done, 0);
            tick = 1'b1;
            @(negedge clk);
            check("gap_cnt_clr_once", cnt_clr, 0);
            run_window(0, tbl[i].cnt, tbl[i].exp_mood, (i == 10) ? 3 : -1);
        end
        tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stopped_busy", busy, 0);
            check("stopped_presc_en", presc_en, 0);
            check("stopped_cnt_clr", cnt_clr, 0);
        end
        check("win_done_pulses", n_done, 12);

        // ena dropped mid-measure: abort without a result, outputs hold 3/1.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ena_presc_en", presc_en, 1);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b0;
        ena = 1'b0;
        @(negedge clk);
        check("ena_busy", busy, 0);
        check("ena_presc_en_off", presc_en, 0);
        check("ena_win_done", win_done, 0);
        check("ena_win_count_hold", win_count, 3);
        check("ena_mood_hold", mood, 1);
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ena_rise_idle", busy, 0);
            check("ena_rise_cnt_clr", cnt_clr, 0);
        end

        // start together with stop stays idle; start alone then enters CLEAR.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        check("ss_busy", busy, 0);
        check("ss_cnt_clr", cnt_clr, 0);
        stop = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("s_cnt_clr", cnt_clr, 1);
        check("s_busy", busy, 1);
        @(negedge clk);
        check("s_presc_en", presc_en, 1);

        // Asynchronous reset in the middle of MEASURE.
        #2 rst_n = 1'b0;
        #1;
        check("arst_presc_en", presc_en, 0);
        check("arst_cnt_clr", cnt_clr, 0);
        check("arst_busy", busy, 0);
        check("arst_win_done", win_done, 0);
        check("arst_win_count", win_count, 0);
        check("arst_mood", mood, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_presc_en", presc_en, 0);
            check("post_rst_busy", busy, 0);
        end

        check("final_win_done_pulses", n_done, 12);
        check("sb_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
